// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: stochastic-to-binary decoder.
// Counts the ones in a stream of 2^BITS accepted samples and presents the count
// as a BITS+1 bit word over a valid/ready handshake.
// Optional feature macro: SC_DECODER_BIPOLAR_EN
//   undefined -> result is the unipolar count of ones (0..2^BITS)
//   defined   -> result is bipolar two's complement 2*ones - 2^BITS, with the
//                all-ones case saturated to +2^BITS-1
module sc_stream_decoder #(
    parameter int unsigned BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_bit,
    input  logic            in_valid,
    output logic            busy,
    output logic [BITS:0]   result,
    output logic            result_valid,
    input  logic            result_ready
);

    // Number of samples in one conversion, as a BITS+1 bit value.
    localparam logic [BITS:0] StreamLen = {1'b1, {BITS{1'b0}}};
    localparam logic [BITS:0] One       = {{BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCount = 2'd1,
        StDone  = 2'd2
    } state_t;

    state_t        state;
    logic [BITS:0] ones_cnt;
    logic [BITS:0] samp_cnt;

    logic [BITS:0] ones_inc;
    logic [BITS:0] samp_inc;
    logic          last_sample;
    logic [BITS:0] final_value;

    // Counter increments for the current sample and end-of-stream detection.
    always_comb begin
        ones_inc    = ones_cnt + {{BITS{1'b0}}, in_bit};
        samp_inc    = samp_cnt + One;
        last_sample = (samp_inc == StreamLen);
    end

`ifdef SC_DECODER_BIPOLAR_EN
    // Bipolar mapping 2*ones - 2^BITS, computed modulo 2^(BITS+1); the
    // all-ones stream would wrap to -2^BITS, so clamp it to +2^BITS-1.
    always_comb begin
        final_value = {ones_inc[BITS-1:0], 1'b0} - StreamLen;
        if (ones_inc == StreamLen) begin
            final_value = {1'b0, {BITS{1'b1}}};
        end
    end
`else
    // Unipolar mapping: the result is the count of ones itself.
    always_comb begin
        final_value = ones_inc;
    end
`endif

    // Control FSM with counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            ones_cnt     <= '0;
            samp_cnt     <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StCount;
                        ones_cnt <= '0;
                        samp_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                StCount: begin
                    if (in_valid) begin
                        ones_cnt <= ones_inc;
                        samp_cnt <= samp_inc;
                        if (last_sample) begin
                            // The final accepted bit is included in the result.
                            result       <= final_value;
                            result_valid <= 1'b1;
                            state        <= StDone;
                        end
                    end
                end
                StDone: begin
                    // result stays put after the handshake until the next completion.
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: begin
                    state        <= StIdle;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed self-checking bench for sc_stream_decoder with BITS=4 (16-sample streams).
module tb_sc_stream_decoder;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_bit;
    logic       in_valid;
    logic       busy;
    logic [4:0] result;
    logic       result_valid;
    logic       result_ready;

    int n_assert = 0;
    int n_fail   = 0;

    sc_stream_decoder #(
        .BITS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_bit       (in_bit),
        .in_valid     (in_valid),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run one conversion: start edge, then 16 samples from pat (LSB first).
    // With gaps, each sample is preceded by one in_valid=0 cycle.
    task automatic convert(input logic [15:0] pat, input bit gaps, input bit hold_start,
                           input string tag);
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_bit   = 1'b1;
                tick();
                check({tag, "_rv_gap"}, {31'd0, result_valid}, 32'd0);
            end
            in_valid = 1'b1;
            in_bit   = pat[i];
            tick();
            if (i < 15) begin
                check({tag, "_rv_early"}, {31'd0, result_valid}, 32'd0);
                check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
            end
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        check({tag, "_rv_done"}, {31'd0, result_valid}, 32'd1);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, "_rv_after_hs"}, {31'd0, result_valid}, 32'd0);
        check({tag, "_busy_after_hs"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        in_bit       = 1'b0;
        in_valid     = 1'b0;
        result_ready = 1'b0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rv", {31'd0, result_valid}, 32'd0);
        check("reset_result", {27'd0, result}, 32'd0);
        rst = 1'b0;
        tick();

        // in_valid while idle must not leak into the next count
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        check("idle_valid_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;

        // 1. All ones
        convert(16'hFFFF, 1'b0, 1'b0, "all_ones");
`ifdef SC_DECODER_BIPOLAR_EN
        check("all_ones_result", {27'd0, result}, 32'd15);
`else
        check("all_ones_result", {27'd0, result}, 32'd16);
`endif

        // 3. Backpressure: hold ready low 5 cycles, pulse start meanwhile
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            check("bp_rv", {31'd0, result_valid}, 32'd1);
            check("bp_busy", {31'd0, busy}, 32'd1);
`ifdef SC_DECODER_BIPOLAR_EN
            check("bp_result", {27'd0, result}, 32'd15);
`else
            check("bp_result", {27'd0, result}, 32'd16);
`endif
        end
        // start on the handshake edge is ignored too
        start = 1'b1;
        handshake("bp");
        start = 1'b0;
        tick();
        check("bp_start_ignored", {31'd0, busy}, 32'd0);
`ifdef SC_DECODER_BIPOLAR_EN
        check("bp_result_held", {27'd0, result}, 32'd15);
`else
        check("bp_result_held", {27'd0, result}, 32'd16);
`endif

        // 2. Alternating 1,0 with a gap before every sample: 32 cycles
        convert(16'h5555, 1'b1, 1'b0, "alt_gaps");
`ifdef SC_DECODER_BIPOLAR_EN
        check("alt_gaps_result", {27'd0, result}, 32'd0);
`else
        check("alt_gaps_result", {27'd0, result}, 32'd8);
`endif
        handshake("alt_gaps");

        // 4. Reset after 7 samples; outputs clear without waiting for an edge
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #2;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rv", {31'd0, result_valid}, 32'd0);
        check("mid_rst_result", {27'd0, result}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        convert(16'h0013, 1'b0, 1'b0, "after_rst");
`ifdef SC_DECODER_BIPOLAR_EN
        check("after_rst_result", {27'd0, result}, 32'd22);   // 6-16 = -10
`else
        check("after_rst_result", {27'd0, result}, 32'd3);
`endif
        handshake("after_rst");
        tick();

        // 5. Bipolar boundary patterns (unipolar expectations when disabled)
        convert(16'h0000, 1'b0, 1'b0, "zeros");
`ifdef SC_DECODER_BIPOLAR_EN
        check("zeros_result", {27'd0, result}, 32'd16);       // 5'b10000
`else
        check("zeros_result", {27'd0, result}, 32'd0);
`endif
        handshake("zeros");
        tick();
        convert(16'hAAAA, 1'b0, 1'b0, "alt");
`ifdef SC_DECODER_BIPOLAR_EN
        check("alt_result", {27'd0, result}, 32'd0);
`else
        check("alt_result", {27'd0, result}, 32'd8);
`endif
        handshake("alt");
        tick();

        // 6. Back-to-back with start held high
        convert(16'hF0FF, 1'b0, 1'b1, "b2b_a");
`ifdef SC_DECODER_BIPOLAR_EN
        check("b2b_a_result", {27'd0, result}, 32'd8);        // 24-16
`else
        check("b2b_a_result", {27'd0, result}, 32'd12);
`endif
        handshake("b2b_a");
        convert(16'h8421, 1'b0, 1'b1, "b2b_b");
`ifdef SC_DECODER_BIPOLAR_EN
        check("b2b_b_result", {27'd0, result}, 32'd24);       // 8-16 = -8
`else
        check("b2b_b_result", {27'd0, result}, 32'd4);
`endif
        start = 1'b0;
        handshake("b2b_b");
        tick();
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Stochastic-to-binary decoder for the stochastic-computing datapath. It counts the ones in a fixed-length bitstream of 2^BITS accepted samples and returns the count as a binary word over a valid/ready handshake. It sits at the output end of the SC arithmetic blocks, for example on the `sum` stream of `sc_n_adder_chain`, and turns their unipolar or bipolar streams back into numbers for checking or downstream binary logic.

## Interface
- `BITS`, default 8: log2 of the stream length; one conversion covers 2^BITS accepted samples.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: begin a conversion; honoured only in IDLE.
- `in_bit` input, 1 bit: stochastic stream bit.
- `in_valid` input, 1 bit: `in_bit` is a sample this cycle.
- `busy` output, 1 bit: high while not in IDLE.
- `result` output, BITS+1 bits: the conversion result.
- `result_valid` output, 1 bit: `result` holds a completed conversion.
- `result_ready` input, 1 bit: the consumer accepts `result`.

## Operation
- FSM states: IDLE, COUNT and DONE.
- **IDLE**
  - `start`=1 at a clock edge → COUNT.
  - On the same edge, clear the ones counter and the sample counter.
- **COUNT**
  - At each edge with `in_valid`=1: sample counter += 1, ones counter += `in_bit`.
  - Edges with `in_valid`=0 change nothing.
  - When the accepting edge brings the sample counter to 2^BITS: register `result` from the final count (including that last bit), go to DONE.
- **DONE**
  - `result_valid`=1 and `result` is held stable.
  - `result_valid` & `result_ready` at an edge → IDLE, `result_valid` drops.
  - `result` keeps its last value until the next conversion completes.
- **`start` outside IDLE:** ignored, including the DONE→IDLE handoff cycle.
- **`in_valid` outside COUNT:** ignored.
- **Width:** the ones counter and `result` are BITS+1 bits wide, so the count 0..2^BITS is exact with no saturation. The sample counter is BITS+1 bits wide.
- **Unipolar result:** `result` = number of ones.
- **Reset, including mid-conversion:** go to IDLE, clear the counters, `busy`=0, `result`=0, `result_valid`=0. The partial count is discarded.

## Timing
- **`start`:** sampled at edge E0. The `in_bit` value present in the E0 cycle is not counted. `busy` is high after E0.
- **Latency:** with `in_valid` held high, samples are taken at edges E1..E2^BITS. `result_valid` is high after edge E2^BITS, i.e. 2^BITS cycles after the start edge.
- **Idle cycles:** each cycle with `in_valid` low adds one cycle of latency.
- **Throughput:** there is a minimum of one IDLE cycle between conversions. The earliest new `start` is sampled on the edge after the handshake edge.
- **Outputs:** all outputs are registered; there is no combinational path from an input to an output.

## Configuration
- Macro `SC_DECODER_BIPOLAR_EN`.
- **Defined:** `result` is bipolar two's complement, computed as 2·ones − 2^BITS, BITS+1 bits wide, range −2^BITS..+2^BITS−… (see the all-ones boundary case below).
- **All-ones boundary in bipolar mode:** all ones gives +2^BITS, which does not fit and wraps. The implementation must saturate this case to +2^BITS−1, i.e. 0 followed by BITS ones.
- **Undefined:** unipolar count as above; the bipolar logic is not compiled.

## Test plan
All scenarios use BITS=4, a 16-sample stream.

1. **All ones, unipolar.** `start` pulse, then `in_bit`=1 with `in_valid`=1 continuously → `result_valid` rises 16 cycles after the start edge with `result`=5'd16; `busy` is high throughout.
2. **Alternating bits with gaps.** Pattern 1,0,1,0… with `in_valid` low every other cycle → `result_valid` rises after 32 cycles with `result`=5'd8.
3. **Backpressure.** Hold `result_ready`=0 for 5 cycles after `result_valid` rises and pulse `start` during that time → `result` and `result_valid` stay stable and `start` is ignored. Then raise `result_ready` for one cycle → back to IDLE, `busy`=0.
4. **Reset mid-count.** Assert `rst` after 7 samples → all outputs are 0 immediately. A new conversion of 3 ones in 16 samples then gives `result`=5'd3.
5. **Bipolar, with `SC_DECODER_BIPOLAR_EN` defined.**
   - All zeros → `result`=5'b10000 (−16).
   - Alternating bits → 5'd0.
   - All ones → 5'b01111 (saturated).
6. **Back-to-back conversions.** `start` is held high continuously → a new conversion begins one cycle after each handshake; two consecutive results with 12 and 4 ones read 5'd12 and 5'd4.
